wb_dev_bridge: RTL and testbench

- Registered Wishbone bridge between one device-facing port of the 2-host/8-device crossbar and a single peripheral.
- Consumes the crossbar's device-side cyc/stb/we/addr/wdata/sel and returns ack/err/rdata.
- Re-times the request and response paths to break the crossbar-to-peripheral combinational path.
- Converts a hung peripheral into a bus error after a programmable timeout, so a host is never locked out of the crossbar.

---
 rtl/wb_dev_bridge.sv | 153 +++++++++++++++
 tb/tb_wb_dev_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dev_bridge.sv
// ============================================================================
// Module  : wb_dev_bridge
// Purpose : Registered Wishbone bridge from one crossbar device port to a
//           single peripheral. It re-times the request and response paths and
//           turns a hung peripheral into a bus error after TIMEOUT cycles.
// Option  : define WBBRIDGE_TIMEOUT_STATUS_EN to add the to_count status port.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_dev_bridge #(
    parameter int DAW     = 24,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wb_up_cyc,
    input  logic           wb_up_stb,
    input  logic           wb_up_we,
    input  logic [DAW-1:0] wb_up_addr,
    input  logic [DW-1:0]  wb_up_wdata,
    input  logic [SW-1:0]  wb_up_sel,
    output logic           wb_up_ack,
    output logic           wb_up_err,
    output logic [DW-1:0]  wb_up_rdata,
    output logic           wb_dn_cyc,
    output logic           wb_dn_stb,
    output logic           wb_dn_we,
    output logic [DAW-1:0] wb_dn_addr,
    output logic [DW-1:0]  wb_dn_wdata,
    output logic [SW-1:0]  wb_dn_sel,
    input  logic           wb_dn_ack,
    input  logic           wb_dn_err,
    input  logic [DW-1:0]  wb_dn_rdata
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
    ,
    output logic [15:0]    to_count
`endif
);

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] c_wait_last = WW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            dn_cyc_q;
    logic            we_q;
    logic [DAW-1:0]  addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   sel_q;
    logic            up_ack_q;
    logic            up_err_q;
    logic [DW-1:0]   rdata_q;
    logic [WW-1:0]   wait_q;
    logic [WW-1:0]   wait_d;
    logic            timeout_d;

    assign wait_d    = wait_q + WW'(1);
    assign timeout_d = (TIMEOUT != 0) && (wait_q == c_wait_last);

`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
    logic [15:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= 16'h0000;
        end else if (state_q == REQ && wb_up_cyc && !wb_dn_ack && !wb_dn_err
                     && timeout_d && to_cnt_q != 16'hFFFF) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign to_count = to_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dn_cyc_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            up_ack_q <= 1'b0;
            up_err_q <= 1'b0;
            rdata_q  <= '0;
            wait_q   <= '0;
        end else begin
            up_ack_q <= 1'b0;
            up_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Stray peripheral responses here belong to an aborted cycle.
                    if (wb_up_cyc && wb_up_stb) begin
                        we_q     <= wb_up_we;
                        addr_q   <= wb_up_addr;
                        wdata_q  <= wb_up_wdata;
                        sel_q    <= wb_up_sel;
                        dn_cyc_q <= 1'b1;
                        wait_q   <= '0;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (!wb_up_cyc) begin
                        dn_cyc_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (wb_dn_ack) begin
                        rdata_q  <= wb_dn_rdata;
                        up_ack_q <= 1'b1;
                        dn_cyc_q <= 1'b0;
                        state_q  <= RESP;
                    end else if (wb_dn_err || timeout_d) begin
                        rdata_q  <= '0;
                        up_err_q <= 1'b1;
                        dn_cyc_q <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        wait_q   <= wait_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    dn_cyc_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign wb_dn_cyc   = dn_cyc_q;
    assign wb_dn_stb   = dn_cyc_q;
    assign wb_dn_we    = we_q;
    assign wb_dn_addr  = addr_q;
    assign wb_dn_wdata = wdata_q;
    assign wb_dn_sel   = sel_q;
    assign wb_up_ack   = up_ack_q;
    assign wb_up_err   = up_err_q;
    assign wb_up_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_dev_bridge.sv
// ============================================================================
// Module  : tb_wb_dev_bridge
// Purpose : Directed scoreboard bench for wb_dev_bridge with TIMEOUT = 8.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_dev_bridge;

    localparam int c_to = 8;
    localparam logic [31:0] c_junk = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_up_cyc = 1'b0;
    logic        wb_up_stb = 1'b0;
    logic        wb_up_we = 1'b0;
    logic [23:0] wb_up_addr = '0;
    logic [31:0] wb_up_wdata = '0;
    logic [3:0]  wb_up_sel = '0;
    logic        wb_up_ack;
    logic        wb_up_err;
    logic [31:0] wb_up_rdata;
    logic        wb_dn_cyc;
    logic        wb_dn_stb;
    logic        wb_dn_we;
    logic [23:0] wb_dn_addr;
    logic [31:0] wb_dn_wdata;
    logic [3:0]  wb_dn_sel;
    logic        wb_dn_ack = 1'b0;
    logic        wb_dn_err = 1'b0;
    logic [31:0] wb_dn_rdata = c_junk;
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
    logic [15:0] to_count;
`endif

    wb_dev_bridge #(
        .DAW     (24),
        .DW      (32),
        .SW      (4),
        .TIMEOUT (c_to)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_up_cyc   (wb_up_cyc),
        .wb_up_stb   (wb_up_stb),
        .wb_up_we    (wb_up_we),
        .wb_up_addr  (wb_up_addr),
        .wb_up_wdata (wb_up_wdata),
        .wb_up_sel   (wb_up_sel),
        .wb_up_ack   (wb_up_ack),
        .wb_up_err   (wb_up_err),
        .wb_up_rdata (wb_up_rdata),
        .wb_dn_cyc   (wb_dn_cyc),
        .wb_dn_stb   (wb_dn_stb),
        .wb_dn_we    (wb_dn_we),
        .wb_dn_addr  (wb_dn_addr),
        .wb_dn_wdata (wb_dn_wdata),
        .wb_dn_sel   (wb_dn_sel),
        .wb_dn_ack   (wb_dn_ack),
        .wb_dn_err   (wb_dn_err),
        .wb_dn_rdata (wb_dn_rdata)
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        ,
        .to_count    (to_count)
`endif
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [33:0] sb[$];
    logic [33:0] mon_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Every upstream ack/err must match the oldest expected response.
    always @(negedge clk) begin
        if (rst && (wb_up_ack || wb_up_err)) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_unexpected: got ack=%0b err=%0b rdata=%h, required no response",
                         wb_up_ack, wb_up_err, wb_up_rdata);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_resp", {wb_up_ack, wb_up_err, wb_up_rdata}, mon_exp);
            end
        end
    end

    // kind: 0 ack, 1 err, 2 no response (timeout), 3 ack and err together.
    task automatic xfer(input logic we, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [3:0] sel, input int w, input int kind, input logic [31:0] prd);
        logic [62:0] bundle;
        logic        ea;
        logic        ee;
        logic [31:0] erd;
        ea  = (kind == 0) || (kind == 3);
        ee  = !ea;
        erd = ea ? prd : 32'h0;
        @(negedge clk);
        wb_up_cyc   = 1'b1;
        wb_up_stb   = 1'b1;
        wb_up_we    = we;
        wb_up_addr  = addr;
        wb_up_wdata = wd;
        wb_up_sel   = sel;
        sb.push_back({ea, ee, erd});
        bundle = {1'b1, 1'b1, we, addr, wd, sel};
        @(negedge clk);
        check("dn_req", {wb_dn_cyc, wb_dn_stb, wb_dn_we, wb_dn_addr, wb_dn_wdata, wb_dn_sel}, bundle);
        check("no_early_resp", {wb_up_ack, wb_up_err}, 2'b00);
        repeat (w) begin
            @(negedge clk);
            check("dn_hold", {wb_dn_cyc, wb_dn_stb, wb_dn_we, wb_dn_addr, wb_dn_wdata, wb_dn_sel}, bundle);
            check("no_early_resp", {wb_up_ack, wb_up_err}, 2'b00);
        end
        if (kind != 2) begin
            wb_dn_rdata = prd;
            wb_dn_ack   = (kind == 0) || (kind == 3);
            wb_dn_err   = (kind == 1) || (kind == 3);
        end
        @(negedge clk);
        wb_dn_ack   = 1'b0;
        wb_dn_err   = 1'b0;
        wb_dn_rdata = c_junk;
        check("resp_flags", {wb_up_ack, wb_up_err, wb_dn_cyc, wb_dn_stb}, {ea, ee, 2'b00});
        wb_up_cyc = 1'b0;
        wb_up_stb = 1'b0;
        wb_up_we  = 1'b0;
        @(negedge clk);
        check("resp_single", {wb_up_ack, wb_up_err, wb_up_rdata}, {2'b00, erd});
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst_dn", {wb_dn_cyc, wb_dn_stb, wb_dn_we, wb_dn_addr, wb_dn_wdata, wb_dn_sel}, '0);
        check("rst_up", {wb_up_ack, wb_up_err, wb_up_rdata}, '0);
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        check("rst_to_count", to_count, 16'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        xfer(1'b0, 24'h000010, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF);
        xfer(1'b1, 24'h000004, 32'h12345678, 4'b0011, 5, 0, 32'hA5A5_0000);
        xfer(1'b0, 24'h000030, 32'h0, 4'hF, 2, 1, 32'h7777_7777);
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        check("to_count_perr", to_count, 16'd0);
`endif
        xfer(1'b0, 24'h000040, 32'h0, 4'hF, c_to - 1, 2, 32'h0);
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        check("to_count_timeout", to_count, 16'd1);
`endif
        xfer(1'b0, 24'h000044, 32'h0, 4'hF, c_to - 1, 0, 32'h0BAD_F00D);
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        check("to_count_ack_wins", to_count, 16'd1);
`endif
        xfer(1'b1, 24'h000050, 32'hFFFF_0000, 4'b1100, 1, 3, 32'h5555_AAAA);

        // Host abort in the third REQ cycle, peripheral acks late.
        @(negedge clk);
        wb_up_cyc  = 1'b1;
        wb_up_stb  = 1'b1;
        wb_up_addr = 24'h000020;
        @(negedge clk);
        check("abort_dn_up", {wb_dn_cyc, wb_dn_stb}, 2'b11);
        @(negedge clk);
        @(negedge clk);
        wb_up_cyc = 1'b0;
        wb_up_stb = 1'b0;
        @(negedge clk);
        check("abort_dn_drop", {wb_dn_cyc, wb_dn_stb, wb_up_ack, wb_up_err}, 4'b0000);
        @(negedge clk);
        wb_dn_ack   = 1'b1;
        wb_dn_rdata = 32'h1111_1111;
        @(negedge clk);
        wb_dn_ack   = 1'b0;
        wb_dn_rdata = c_junk;
        check("late_ack_ignored", {wb_dn_cyc, wb_up_ack, wb_up_err}, 3'b000);
        @(negedge clk);
        check("late_ack_idle", {wb_dn_cyc, wb_up_ack, wb_up_err, wb_up_rdata}, {3'b000, 32'h5555_AAAA});
        xfer(1'b0, 24'h000024, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a REQ wait.
        @(negedge clk);
        wb_up_cyc  = 1'b1;
        wb_up_stb  = 1'b1;
        wb_up_we   = 1'b1;
        wb_up_addr = 24'h000abc;
        wb_up_wdata = 32'h0102_0304;
        wb_up_sel  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_dn", {wb_dn_cyc, wb_dn_stb, wb_dn_we, wb_dn_addr, wb_dn_wdata, wb_dn_sel}, '0);
        check("arst_up", {wb_up_ack, wb_up_err, wb_up_rdata}, '0);
`ifdef WBBRIDGE_TIMEOUT_STATUS_EN
        check("arst_to_count", to_count, 16'd0);
`endif
        @(negedge clk);
        wb_up_cyc = 1'b0;
        wb_up_stb = 1'b0;
        wb_up_we  = 1'b0;
        rst = 1'b1;
        xfer(1'b0, 24'h000100, 32'h0, 4'hF, 0, 0, 32'h600D_CAFE);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
